// File: rtl/mem_access_stage.sv
// MEM pipeline stage: wait-stated data memory with byte/half/word loads and stores.
// Optional misalignment trapping is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int WAIT_STATES     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic        RegWrite,
    input  logic        MemToReg,
    input  logic [4:0]  WriteReg,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic [4:0]  WriteReg_out,
    output logic [31:0] ALUResult_out,
    output logic [31:0] MemData_out,
    output logic        MemStall,
    output logic        MemAlignErr
);

    localparam int AW = $clog2(MEM_DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES >= 2) ? 4'(WAIT_STATES - 2) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        access, is_load;
    logic        stall_raw, complete, misalign, align_err, store_en;
    logic [1:0]  lane_off;
    logic [3:0]  byte_en;
    logic [31:0] wdata, rdata;
    logic [AW-1:0] word_idx;
    logic [31:0] mem [MEM_DEPTH_WORDS];

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                                 input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_align(input logic [31:0] d, input logic [1:0] size);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    assign access  = MemRead | MemWrite;
    assign is_load = MemRead & ~MemWrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (access) begin
                    if (WAIT_STATES >= 2) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end else if (WAIT_STATES == 1) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_DONE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the IDLE cycle itself is the completing cycle.
    always_comb begin
        stall_raw = 1'b0;
        complete  = 1'b0;
        case (state)
            S_IDLE: begin
                stall_raw = access && (WAIT_STATES != 0);
                complete  = access && (WAIT_STATES == 0);
            end
            S_WAIT:  stall_raw = 1'b1;
            S_DONE:  complete  = access;
            default: ;
        endcase
    end

    assign word_idx = ALUResult[AW+1:2];
    assign misalign = ((MemSize == 2'b01) && ALUResult[0]) ||
                      (MemSize[1] && (ALUResult[1:0] != 2'b00));

`ifdef MEM_ALIGN_CHECK_EN
    assign lane_off  = ALUResult[1:0];
    assign align_err = complete & misalign & rst_n;
`else
    assign lane_off  = (MemSize == 2'b00) ? ALUResult[1:0] :
                       (MemSize == 2'b01) ? {ALUResult[1], 1'b0} : 2'b00;
    assign align_err = 1'b0;
`endif

    assign byte_en  = lane_mask(MemSize, lane_off);
    assign wdata    = store_align(WriteData, MemSize);
    assign store_en = complete & MemWrite & ~align_err & rst_n;
    assign rdata    = mem[word_idx];

    // Memory is deliberately left out of reset; only addressed lanes are written.
    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign MemStall      = stall_raw & rst_n;
    assign MemAlignErr   = align_err;
    assign MemData_out   = is_load ? load_extract(rdata, MemSize, lane_off, MemSigned) : 32'd0;
    assign RegWrite_out  = RegWrite & ~MemStall & ~align_err;
    assign MemToReg_out  = MemToReg;
    assign WriteReg_out  = WriteReg;
    assign ALUResult_out = ALUResult;

    wire unused_misalign = misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scoreboard bench for mem_access_stage with WAIT_STATES=2.
// Expectations for the misalignment cases follow MEM_ALIGN_CHECK_EN.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite, MemSigned, RegWrite, MemToReg;
    logic [1:0]  MemSize;
    logic [31:0] ALUResult, WriteData;
    logic [4:0]  WriteReg;
    logic        RegWrite_out, MemToReg_out, MemStall, MemAlignErr;
    logic [4:0]  WriteReg_out;
    logic [31:0] ALUResult_out, MemData_out;

    mem_access_stage #(.MEM_DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .MemSigned(MemSigned), .ALUResult(ALUResult),
        .WriteData(WriteData), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .WriteReg(WriteReg), .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
        .WriteReg_out(WriteReg_out), .ALUResult_out(ALUResult_out),
        .MemData_out(MemData_out), .MemStall(MemStall), .MemAlignErr(MemAlignErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [4:0]  wreg;
        logic        m2r;
        logic [31:0] data;
        int          stalls;
        logic        rw;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   issued = 0;
    int   retired = 0;
    int   stall_cnt = 0;

`ifdef MEM_ALIGN_CHECK_EN
    localparam logic        MIS_ERR  = 1'b1;
    localparam logic        MIS_RW   = 1'b0;
    localparam logic [31:0] MIS_WORD = 32'h11111111;
`else
    localparam logic        MIS_ERR  = 1'b0;
    localparam logic        MIS_RW   = 1'b1;
    localparam logic [31:0] MIS_WORD = 32'h99999999;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic drive_idle();
        MemRead = 0; MemWrite = 0; MemSize = 2'b10; MemSigned = 0;
        ALUResult = 32'h0; WriteData = 32'h0; RegWrite = 0; MemToReg = 0; WriteReg = 5'd0;
    endtask

    // Called just after a rising edge; returns on the edge that retires the op.
    task automatic issue(input string name, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                         input logic rw, input logic m2r, input logic [4:0] wreg,
                         input logic [31:0] exp_data, input int exp_stalls,
                         input logic exp_rw, input logic exp_err);
        exp_t e;
        bit   done;
        e.name = name; e.addr = addr; e.wreg = wreg; e.m2r = m2r;
        e.data = exp_data; e.stalls = exp_stalls; e.rw = exp_rw; e.err = exp_err;
        exp_q.push_back(e);
        #1;
        MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sgn; ALUResult = addr;
        WriteData = wd; RegWrite = rw; MemToReg = m2r; WriteReg = wreg;
        issued++;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            if (retired == issued) done = 1;
        end
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: got no completion expected completion within 20 cycles", name);
            summary();
        end
    endtask

    initial begin
        rst_n = 0;
        drive_idle();
        MemWrite = 1;
        #12;
        chk("reset_stall", MemStall, 0);
        chk("reset_alignerr", MemAlignErr, 0);
        drive_idle();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        fork
            begin
                issue("sw_deadbeef", 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 5'd0, 32'h0, 2, 0, 0);
                issue("lw_10", 1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 1, 5'd3, 32'hDEADBEEF, 2, 1, 0);
                issue("lb_13", 1, 0, 2'b00, 1, 32'h13, 32'h0, 1, 1, 5'd4, 32'hFFFFFFDE, 2, 1, 0);
                issue("lbu_13", 1, 0, 2'b00, 0, 32'h13, 32'h0, 1, 1, 5'd4, 32'h000000DE, 2, 1, 0);
                issue("lh_10", 1, 0, 2'b01, 1, 32'h10, 32'h0, 1, 1, 5'd6, 32'hFFFFBEEF, 2, 1, 0);
                issue("sh_12", 0, 1, 2'b01, 0, 32'h12, 32'hFFFF1234, 0, 0, 5'd0, 32'h0, 2, 0, 0);
                issue("lw_after_sh", 1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 1, 5'd7, 32'h1234BEEF, 2, 1, 0);
                issue("alu_a", 0, 0, 2'b10, 0, 32'h55, 32'h0, 1, 0, 5'd5, 32'h0, 0, 1, 0);
                issue("alu_b", 0, 0, 2'b10, 0, 32'hAA, 32'h0, 1, 0, 5'd5, 32'h0, 0, 1, 0);
                issue("sb_11", 0, 1, 2'b00, 0, 32'h11, 32'h777777A5, 0, 0, 5'd0, 32'h0, 2, 0, 0);
                issue("lw_after_sb", 1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 1, 5'd8, 32'h1234A5EF, 2, 1, 0);
                issue("lw_wrap", 1, 0, 2'b10, 0, 32'h1010, 32'h0, 1, 1, 5'd9, 32'h1234A5EF, 2, 1, 0);
                issue("rd_wr_both", 1, 1, 2'b10, 0, 32'h30, 32'h0F0F0F0F, 0, 0, 5'd0, 32'h0, 2, 0, 0);
                issue("lw_30", 1, 0, 2'b10, 0, 32'h30, 32'h0, 1, 1, 5'd10, 32'h0F0F0F0F, 2, 1, 0);
                issue("lhu_12", 1, 0, 2'b01, 0, 32'h12, 32'h0, 1, 1, 5'd11, 32'h00001234, 2, 1, 0);
                issue("sw_20", 0, 1, 2'b10, 0, 32'h20, 32'h11111111, 0, 0, 5'd0, 32'h0, 2, 0, 0);

                // Store interrupted by reset while in WAIT.
                #1;
                MemWrite = 1; MemSize = 2'b10; ALUResult = 32'h20; WriteData = 32'hAAAAAAAA;
                @(posedge clk);
                @(negedge clk);
                chk("wait_stall", MemStall, 1);
                rst_n = 0;
                #1;
                chk("rst_mid_stall", MemStall, 0);
                chk("rst_mid_alignerr", MemAlignErr, 0);
                @(posedge clk);
                #1;
                drive_idle();
                @(negedge clk);
                rst_n = 1;
                @(posedge clk);
                issue("lw_20_after_rst", 1, 0, 2'b10, 0, 32'h20, 32'h0, 1, 1, 5'd12, 32'h11111111, 2, 1, 0);

                issue("sw_mis_22", 0, 1, 2'b10, 0, 32'h22, 32'h99999999, 0, 0, 5'd0, 32'h0, 2, 0, MIS_ERR);
                issue("lw_20_after_mis", 1, 0, 2'b10, 0, 32'h20, 32'h0, 1, 1, 5'd13, MIS_WORD, 2, 1, 0);
                issue("lhu_mis_11", 1, 0, 2'b01, 0, 32'h11, 32'h0, 1, 1, 5'd14, 32'h0000A5EF, 2, MIS_RW, MIS_ERR);
                #1;
                drive_idle();
                repeat (2) @(posedge clk);
            end
            begin
                forever begin
                    @(negedge clk);
                    if (retired < issued) begin
                        if (MemStall) begin
                            stall_cnt++;
                            chk("stall_regwrite_bubble", RegWrite_out, 0);
                        end else if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL scoreboard_empty: got completion expected none");
                            retired++;
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            chk({e.name, "_data"}, MemData_out, e.data);
                            chk({e.name, "_stalls"}, stall_cnt, e.stalls);
                            chk({e.name, "_regwrite"}, RegWrite_out, e.rw);
                            chk({e.name, "_alignerr"}, MemAlignErr, e.err);
                            chk({e.name, "_aluout"}, ALUResult_out, e.addr);
                            chk({e.name, "_wreg"}, WriteReg_out, e.wreg);
                            chk({e.name, "_m2r"}, MemToReg_out, e.m2r);
                            stall_cnt = 0;
                            retired++;
                        end
                    end
                end
            end
        join_any
        summary();
    end

endmodule
